// File: rtl/rs_issue_queue_if.sv
// rtl/rs_issue_queue_if.sv - shared widths/types and the RS<->FU issue/wakeup interface
//
// rs_pkg          : fu_op_t, nzcv_t, cond_t and the operand/ROB widths.
// rs_issue_queue_if:
//   in_fu_done / in_fu_dst_rob_index / in_fu_value  FU completion broadcast (wakeup)
//   in_alu_ready / in_ls_ready                      FU can accept ALU / LS op
//   out_alu_*                                       ALU issue bundle (start pulse + operands)
//   out_ls_*                                        LS issue bundle (start pulse + operands)
//   modport master : reservation station (initiator)
//   modport slave  : functional-unit block

`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package rs_pkg;
    localparam int GPR_W = `GPR_SIZE;
    localparam int ROB_W = `ROB_IDX_SIZE;

    typedef enum logic [3:0] {
        FU_PLUS  = 4'd0,
        FU_MINUS = 4'd1,
        FU_AND   = 4'd2,
        FU_ORR   = 4'd3,
        FU_CSEL  = 4'd4,
        FU_LDR   = 4'd5,
        FU_STR   = 4'd6
    } fu_op_t;

    typedef logic [3:0] nzcv_t;
    typedef logic [3:0] cond_t;
endpackage

interface rs_issue_queue_if;
    import rs_pkg::*;

    logic                 in_fu_done;
    logic [ROB_W-1:0]     in_fu_dst_rob_index;
    logic [GPR_W-1:0]     in_fu_value;

    logic                 in_alu_ready;
    logic                 in_ls_ready;

    logic                 out_alu_start;
    fu_op_t               out_alu_op;
    logic [GPR_W-1:0]     out_alu_val_a;
    logic [GPR_W-1:0]     out_alu_val_b;
    logic [ROB_W-1:0]     out_alu_dst_rob_index;
    logic                 out_alu_set_nzcv;
    nzcv_t                out_alu_nzcv;
    cond_t                out_alu_cond_codes;

    logic                 out_ls_start;
    fu_op_t               out_ls_op;
    logic [GPR_W-1:0]     out_ls_val_a;
    logic [GPR_W-1:0]     out_ls_val_b;
    logic [ROB_W-1:0]     out_ls_dst_rob_index;

    modport master (
        input  in_fu_done, in_fu_dst_rob_index, in_fu_value,
        input  in_alu_ready, in_ls_ready,
        output out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
        output out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv, out_alu_cond_codes,
        output out_ls_start, out_ls_op, out_ls_val_a, out_ls_val_b, out_ls_dst_rob_index
    );

    modport slave (
        output in_fu_done, in_fu_dst_rob_index, in_fu_value,
        output in_alu_ready, in_ls_ready,
        input  out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
        input  out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv, out_alu_cond_codes,
        input  out_ls_start, out_ls_op, out_ls_val_a, out_ls_val_b, out_ls_dst_rob_index
    );
endinterface

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - Tomasulo reservation-station issue queue (collapsing, oldest-first)
//
// Ports:
//   in_clk, in_rst_n        clock, async active-low reset
//   in_flush                synchronous squash of all entries
//   in_disp_*               dispatch request and decoded micro-op fields
//   out_disp_full           registered queue-full flag; dispatch ignored while high
//   fu (master)             completion-bus wakeup, FU ready inputs, ALU/LS issue bundles

module rs_issue_queue
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_flush,
    input  logic                 in_disp_valid,
    input  logic                 in_disp_is_ls,
    input  fu_op_t               in_disp_op,
    input  logic [GPR_W-1:0]     in_disp_val_a,
    input  logic [GPR_W-1:0]     in_disp_val_b,
    input  logic                 in_disp_a_ready,
    input  logic                 in_disp_b_ready,
    input  logic [ROB_W-1:0]     in_disp_a_tag,
    input  logic [ROB_W-1:0]     in_disp_b_tag,
    input  logic [ROB_W-1:0]     in_disp_dst_rob_index,
    input  logic                 in_disp_set_nzcv,
    input  nzcv_t                in_disp_nzcv,
    input  cond_t                in_disp_cond,
    output logic                 out_disp_full,
    rs_issue_queue_if.master     fu
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic             is_ls;
        fu_op_t           op;
        logic [GPR_W-1:0] val_a;
        logic [GPR_W-1:0] val_b;
        logic             a_rdy;
        logic             b_rdy;
        logic [ROB_W-1:0] a_tag;
        logic [ROB_W-1:0] b_tag;
        logic [ROB_W-1:0] dst;
        logic             set_nzcv;
        nzcv_t            nzcv;
        cond_t            cond;
    } entry_t;

    // Validity is implied by position: entries [0, count-1] are live.
    entry_t            q     [NUM_ENTRIES];
    entry_t            q_nxt [NUM_ENTRIES];
    entry_t            woke  [NUM_ENTRIES];
    entry_t            disp_e;
    entry_t            sel_e;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  disp_pos;
    logic [IDX_W-1:0]  sel_idx;
    logic              found;
    logic              issue;
    logic              accept;

    always_comb begin
        disp_e    = '0;
        sel_idx   = '0;
        found     = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        disp_pos  = count;
        count_nxt = count;
        sel_e     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woke[i]  = q[i];
            q_nxt[i] = q[i];
        end

        // Incoming op, with a same-edge completion captured as a bypass.
        disp_e.is_ls    = in_disp_is_ls;
        disp_e.op       = in_disp_op;
        disp_e.val_a    = in_disp_val_a;
        disp_e.val_b    = in_disp_val_b;
        disp_e.a_rdy    = in_disp_a_ready;
        disp_e.b_rdy    = in_disp_b_ready;
        disp_e.a_tag    = in_disp_a_tag;
        disp_e.b_tag    = in_disp_b_tag;
        disp_e.dst      = in_disp_dst_rob_index;
        disp_e.set_nzcv = in_disp_set_nzcv;
        disp_e.nzcv     = in_disp_nzcv;
        disp_e.cond     = in_disp_cond;
        if (fu.in_fu_done && !in_disp_a_ready && in_disp_a_tag == fu.in_fu_dst_rob_index) begin
            disp_e.val_a = fu.in_fu_value;
            disp_e.a_rdy = 1'b1;
        end
        if (fu.in_fu_done && !in_disp_b_ready && in_disp_b_tag == fu.in_fu_dst_rob_index) begin
            disp_e.val_b = fu.in_fu_value;
            disp_e.b_rdy = 1'b1;
        end

        // Wakeup snoop on every stored entry; dead slots are harmless.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (fu.in_fu_done && !q[i].a_rdy && q[i].a_tag == fu.in_fu_dst_rob_index) begin
                woke[i].val_a = fu.in_fu_value;
                woke[i].a_rdy = 1'b1;
            end
            if (fu.in_fu_done && !q[i].b_rdy && q[i].b_tag == fu.in_fu_dst_rob_index) begin
                woke[i].val_b = fu.in_fu_value;
                woke[i].b_rdy = 1'b1;
            end
        end

        // Oldest-first select on pre-edge state; one issue across both classes.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!found && CNT_W'(i) < count && q[i].a_rdy && q[i].b_rdy &&
                (q[i].is_ls ? fu.in_ls_ready : fu.in_alu_ready)) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        sel_e  = q[sel_idx];
        issue  = found && !in_flush;
        accept = in_disp_valid && !out_disp_full && !in_flush;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            q_nxt[i] = woke[i];
        end
        if (issue) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    q_nxt[i] = woke[i + 1];
                end
            end
        end

        // With a simultaneous issue the tail has moved down one slot.
        disp_pos = issue ? count - CNT_W'(1) : count;
        if (accept) begin
            q_nxt[IDX_W'(disp_pos)] = disp_e;
        end

        if (in_flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count - CNT_W'(issue) + CNT_W'(accept);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                q[i] <= '0;
            end
            count                    <= '0;
            out_disp_full            <= 1'b0;
            fu.out_alu_start         <= 1'b0;
            fu.out_alu_op            <= FU_PLUS;
            fu.out_alu_val_a         <= '0;
            fu.out_alu_val_b         <= '0;
            fu.out_alu_dst_rob_index <= '0;
            fu.out_alu_set_nzcv      <= 1'b0;
            fu.out_alu_nzcv          <= '0;
            fu.out_alu_cond_codes    <= '0;
            fu.out_ls_start          <= 1'b0;
            fu.out_ls_op             <= FU_PLUS;
            fu.out_ls_val_a          <= '0;
            fu.out_ls_val_b          <= '0;
            fu.out_ls_dst_rob_index  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                q[i] <= q_nxt[i];
            end
            count            <= count_nxt;
            out_disp_full    <= (count_nxt == CNT_W'(NUM_ENTRIES));
            fu.out_alu_start <= issue && !sel_e.is_ls;
            fu.out_ls_start  <= issue && sel_e.is_ls;
            if (issue && !sel_e.is_ls) begin
                fu.out_alu_op            <= sel_e.op;
                fu.out_alu_val_a         <= sel_e.val_a;
                fu.out_alu_val_b         <= sel_e.val_b;
                fu.out_alu_dst_rob_index <= sel_e.dst;
                fu.out_alu_set_nzcv      <= sel_e.set_nzcv;
                fu.out_alu_nzcv          <= sel_e.nzcv;
                fu.out_alu_cond_codes    <= sel_e.cond;
            end
            if (issue && sel_e.is_ls) begin
                fu.out_ls_op            <= sel_e.op;
                fu.out_ls_val_a         <= sel_e.val_a;
                fu.out_ls_val_b         <= sel_e.val_b;
                fu.out_ls_dst_rob_index <= sel_e.dst;
            end
        end
    end

endmodule
